d_mem_lsu: RTL and testbench

Load/store initiator that sits in the MEM pipeline stage between the core and the word-aligned data memory (`mem`). It takes one load or store request at a time and drives the memory's byte-address and byte-enable interface. It splits any access that crosses a 32-bit word boundary into two word accesses, reassembles load data and applies sign or zero extension. It also flags out-of-range or illegal accesses without touching memory.

---
 rtl/d_mem_lsu.sv | 186 ++++++++++++++++++
 tb/tb_d_mem_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_lsu.sv
// Load/store initiator between the MEM stage and a word-aligned data memory.
// Splits word-crossing accesses into two memory cycles, merges load data and extends it.
module d_mem_lsu #(
   parameter int unsigned WORD_WIDTH      = 32,
   parameter int unsigned ADRS_WIDTH      = 32,
   parameter int unsigned MEM_DEPTH_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADRS_WIDTH-1:0] req_adrs,
   input  logic [WORD_WIDTH-1:0] req_wr_data,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [WORD_WIDTH-1:0] resp_rd_data,
   output logic [ADRS_WIDTH-1:0] mem_adrs,
   output logic                  mem_rden,
   output logic                  mem_wren,
   output logic [3:0]            mem_byt_en,
   output logic                  mem_sign_ext,
   output logic [WORD_WIDTH-1:0] mem_wr_data,
   input  logic [WORD_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   localparam logic [ADRS_WIDTH-1:0] DEPTH    = ADRS_WIDTH'(MEM_DEPTH_WORDS);
   localparam logic [ADRS_WIDTH-1:0] ONE_A    = ADRS_WIDTH'(1);
   localparam logic [ADRS_WIDTH-3:0] ONE_W    = (ADRS_WIDTH-2)'(1);
   localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;

   state_t state, state_nxt;

   logic                  cur_we;
   logic [1:0]            cur_size;
   logic                  cur_unsigned;
   logic [ADRS_WIDTH-1:0] cur_adrs;
   logic [WORD_WIDTH-1:0] cur_wr_data;
   logic                  cur_split;

   logic [WORD_WIDTH-1:0] ld_buf, buf_nxt;
   logic                  resp_valid_nxt, resp_err_nxt;
   logic [WORD_WIDTH-1:0] resp_data_nxt;

   logic [2:0]            req_bytes;
   logic [2:0]            req_end;
   logic                  req_split;
   logic [ADRS_WIDTH-1:0] req_word, req_word_nxt;
   logic                  req_fault;
   logic                  accept;

   logic [3:0]            cur_mask;
   logic [2:0]            hi_bytes;
   logic [5:0]            hi_shift;
   logic [WORD_WIDTH-1:0] lo_keep;
   logic [ADRS_WIDTH-1:0] hi_adrs;

   function automatic logic [WORD_WIDTH-1:0] extend(input logic [WORD_WIDTH-1:0] d,
                                                    input logic [1:0] sz,
                                                    input logic uns);
      case (sz)
         2'b00:   extend = {{24{~uns & d[7]}}, d[7:0]};
         2'b01:   extend = {{16{~uns & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   // Request decode: size, split detection and range check on the incoming request
   always_comb begin
      case (req_size)
         2'b00:   req_bytes = 3'd1;
         2'b01:   req_bytes = 3'd2;
         default: req_bytes = 3'd4;
      endcase
      req_end      = {1'b0, req_adrs[1:0]} + req_bytes;
      req_split    = (req_end > 3'd4);
      req_word     = {2'b00, req_adrs[ADRS_WIDTH-1:2]};
      req_word_nxt = req_word + ONE_A;
      req_fault    = (req_size == 2'b11) || (req_word >= DEPTH) ||
                     (req_split && (req_word_nxt >= DEPTH));
   end

   assign req_ready    = (state == IDLE);
   assign accept       = req_valid && req_ready;
   assign mem_sign_ext = 1'b0;

   always_comb begin
      case (cur_size)
         2'b00:   cur_mask = 4'b0001;
         2'b01:   cur_mask = 4'b0011;
         default: cur_mask = 4'b1111;
      endcase
      hi_bytes = 3'd4 - {1'b0, cur_adrs[1:0]};
      hi_shift = {hi_bytes, 3'b000};
      // LO leaves only the low (4 - offset) bytes of the buffer valid
      lo_keep  = ALL_ONES >> {cur_adrs[1:0], 3'b000};
      hi_adrs  = {cur_adrs[ADRS_WIDTH-1:2] + ONE_W, 2'b00};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cur_we       <= 1'b0;
         cur_size     <= '0;
         cur_unsigned <= 1'b0;
         cur_adrs     <= '0;
         cur_wr_data  <= '0;
         cur_split    <= 1'b0;
         ld_buf       <= '0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rd_data <= '0;
      end else begin
         state        <= state_nxt;
         ld_buf       <= buf_nxt;
         resp_valid   <= resp_valid_nxt;
         resp_err     <= resp_err_nxt;
         resp_rd_data <= resp_data_nxt;
         if (accept && !req_fault) begin
            cur_we       <= req_we;
            cur_size     <= req_size;
            cur_unsigned <= req_unsigned;
            cur_adrs     <= req_adrs;
            cur_wr_data  <= req_wr_data;
            cur_split    <= req_split;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      buf_nxt        = ld_buf;
      resp_valid_nxt = 1'b0;
      resp_err_nxt   = 1'b0;
      resp_data_nxt  = '0;
      mem_adrs       = '0;
      mem_rden       = 1'b0;
      mem_wren       = 1'b0;
      mem_byt_en     = '0;
      mem_wr_data    = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_fault) begin
                  resp_valid_nxt = 1'b1;
                  resp_err_nxt   = 1'b1;
               end else begin
                  state_nxt = LO;
               end
            end
         end
         LO: begin
            mem_adrs    = cur_adrs;
            mem_byt_en  = cur_mask;
            mem_rden    = !cur_we;
            mem_wren    = cur_we;
            mem_wr_data = cur_wr_data;
            if (!cur_we) buf_nxt = mem_rd_data;
            if (cur_split) begin
               state_nxt = HI;
            end else begin
               state_nxt      = IDLE;
               resp_valid_nxt = 1'b1;
               if (!cur_we) resp_data_nxt = extend(buf_nxt, cur_size, cur_unsigned);
            end
         end
         HI: begin
            mem_adrs    = hi_adrs;
            mem_byt_en  = cur_mask >> hi_bytes;
            mem_rden    = !cur_we;
            mem_wren    = cur_we;
            mem_wr_data = cur_wr_data >> hi_shift;
            if (!cur_we) buf_nxt = (ld_buf & lo_keep) | ((mem_rd_data << hi_shift) & ~lo_keep);
            state_nxt      = IDLE;
            resp_valid_nxt = 1'b1;
            if (!cur_we) resp_data_nxt = extend(buf_nxt, cur_size, cur_unsigned);
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Scoreboard bench for d_mem_lsu with a byte-enable word memory model.
module tb_d_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_adrs = '0;
   logic [31:0] req_wr_data = '0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rd_data;
   logic [31:0] mem_adrs;
   logic        mem_rden, mem_wren, mem_sign_ext;
   logic [3:0]  mem_byt_en;
   logic [31:0] mem_wr_data, mem_rd_data;

   always #5 clk = ~clk;

   d_mem_lsu #(.WORD_WIDTH(32), .ADRS_WIDTH(32), .MEM_DEPTH_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_adrs(req_adrs),
      .req_wr_data(req_wr_data),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rd_data(resp_rd_data),
      .mem_adrs(mem_adrs), .mem_rden(mem_rden), .mem_wren(mem_wren),
      .mem_byt_en(mem_byt_en), .mem_sign_ext(mem_sign_ext),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   // Memory model: enables and data are shifted up by the byte offset, reads shifted down
   logic [31:0] mem [0:255];
   logic        load_mem = 1'b1;

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[1]   <= 32'hDDCCBBAA;
         mem[2]   <= 32'h44332211;
         mem[4]   <= 32'h12345678;
         mem[255] <= 32'hCAFEF00D;
      end else if (mem_wren && mem_adrs[31:10] == '0) begin
         for (int i = 0; i < 4; i++)
            if (mem_byt_en[i] && (i + int'(mem_adrs[1:0])) < 4)
               mem[mem_adrs[9:2]][8*(i+int'(mem_adrs[1:0])) +: 8] <= mem_wr_data[8*i +: 8];
      end
   end

   always_comb begin
      mem_rd_data = '0;
      if (mem_rden && mem_adrs[31:10] == '0)
         mem_rd_data = mem[mem_adrs[9:2]] >> {mem_adrs[1:0], 3'b000};
   end

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [31:0] adrs;
      logic [3:0]  en;
      logic        we;
      logic [31:0] wd;
   } mop_t;

   rsp_t rq[$];
   mop_t mq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic mop_t mop(input logic [31:0] a, input logic [3:0] en,
                                input logic we, input logic [31:0] wd);
      mop_t m;
      m.adrs = a; m.en = en; m.we = we; m.wd = wd;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (rq.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = rq.pop_front();
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_rd_data", resp_rd_data, e.data);
            chk("resp_cycle", cyc, e.cyc);
         end
      end
   end

   // Memory-interface monitor
   always @(negedge clk) begin
      chk("mem_sign_ext", {31'b0, mem_sign_ext}, 32'd0);
      if (mem_rden || mem_wren) begin
         if (mq.size() == 0) begin
            chk("mem_unexpected", 32'd1, 32'd0);
         end else begin
            mop_t o;
            o = mq.pop_front();
            chk("mem_adrs", mem_adrs, o.adrs);
            chk("mem_byt_en", {28'b0, mem_byt_en}, {28'b0, o.en});
            chk("mem_wren", {31'b0, mem_wren}, {31'b0, o.we});
            chk("mem_rden", {31'b0, mem_rden}, {31'b0, ~o.we});
            chk("mem_wr_data", mem_wr_data, o.wd);
         end
      end else begin
         chk("mem_idle_adrs", mem_adrs, 32'd0);
         chk("mem_idle_en", {28'b0, mem_byt_en}, 32'd0);
         chk("mem_idle_wd", mem_wr_data, 32'd0);
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] adrs, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_data, input int lat,
                        input int nops, input mop_t op0, input mop_t op1,
                        output int acc);
      int waited;
      rsp_t r;
      waited = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_adrs = adrs; req_wr_data = wd;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      r.err = exp_err; r.data = exp_data; r.cyc = acc + lat - 1;
      rq.push_back(r);
      if (nops > 0) mq.push_back(op0);
      if (nops > 1) mq.push_back(op1);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   mop_t none;
   int   a1, a2, ax;

   initial begin
      none = mop(32'h0, 4'h0, 1'b0, 32'h0);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_data", resp_rd_data, 32'd0);
      chk("rst_mem_en", {30'b0, mem_rden, mem_wren}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      load_mem = 1'b0;

      issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b0, 32'hFFFFFFDD, 2,
            1, mop(32'h7, 4'b0001, 1'b0, 32'h0), none, ax);
      issue(1'b0, 2'b01, 1'b1, 32'h7, 32'h0, 1'b0, 32'h000011DD, 3,
            2, mop(32'h7, 4'b0011, 1'b0, 32'h0), mop(32'h8, 4'b0001, 1'b0, 32'h0), ax);
      issue(1'b1, 2'b10, 1'b0, 32'h6, 32'hA1B2C3D4, 1'b0, 32'h0, 3,
            2, mop(32'h6, 4'b1111, 1'b1, 32'hA1B2C3D4), mop(32'h8, 4'b0011, 1'b1, 32'h0000A1B2), ax);
      issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 32'hC3D4BBAA, 2,
            1, mop(32'h4, 4'b1111, 1'b0, 32'h0), none, a1);
      issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'h4433A1B2, 2,
            1, mop(32'h8, 4'b1111, 1'b0, 32'h0), none, a2);
      chk("b2b_accept_gap", a2 - a1, 32'd2);
      issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 1'b0, 32'hFFFFC3D4, 2,
            1, mop(32'h6, 4'b0011, 1'b0, 32'h0), none, ax);
      issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b0, 32'h000000BB, 2,
            1, mop(32'h5, 4'b0001, 1'b0, 32'h0), none, ax);
      issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 1'b0, 32'hB2C3D4BB, 3,
            2, mop(32'h5, 4'b1111, 1'b0, 32'h0), mop(32'h8, 4'b0001, 1'b0, 32'h0), ax);

      // Faults: no memory traffic expected, so the mem monitor flags any access
      issue(1'b0, 2'b10, 1'b0, 32'd1022, 32'h0, 1'b1, 32'h0, 1, 0, none, none, ax);
      issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0, none, none, ax);
      issue(1'b0, 2'b00, 1'b1, 32'd1024, 32'h0, 1'b1, 32'h0, 1, 0, none, none, ax);
      idle(4);
      chk("mem_word4", mem[4], 32'h12345678);
      chk("mem_word255", mem[255], 32'hCAFEF00D);
      chk("mem_word1", mem[1], 32'hC3D4BBAA);
      chk("mem_word2", mem[2], 32'h4433A1B2);

      // Reset asserted during the HI cycle of a split store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_adrs = 32'h6; req_wr_data = 32'h55667788;
      @(posedge clk);
      #1;
      mq.push_back(mop(32'h6, 4'b1111, 1'b1, 32'h55667788));
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_hi_mem_en", {30'b0, mem_rden, mem_wren}, 32'd0);
      chk("rst_hi_mem_adrs", mem_adrs, 32'd0);
      chk("rst_hi_mem_byt_en", {28'b0, mem_byt_en}, 32'd0);
      chk("rst_hi_mem_wr_data", mem_wr_data, 32'd0);
      chk("rst_hi_resp_valid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hi_word1", mem[1], 32'h7788BBAA);
      chk("rst_hi_word2", mem[2], 32'h4433A1B2);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 32'h7788BBAA, 2,
            1, mop(32'h4, 4'b1111, 1'b0, 32'h0), none, ax);
      issue(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 1'b0, 32'h4433A1B2, 2,
            1, mop(32'h8, 4'b1111, 1'b0, 32'h0), none, ax);
      idle(1);

      for (int i = 0; i < 50 && (rq.size() != 0 || mq.size() != 0); i++) @(negedge clk);
      chk("resp_queue_drained", rq.size(), 32'd0);
      chk("mem_queue_drained", mq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
